// File: rtl/matrix_op_if.sv
// Key-event and result bundle between the encoders, the matrix controller and the display stage.
interface matrix_op_if #(
    parameter int DW = 4,
    parameter int RW = DW + 1
);
    logic              digit_valid;
    logic [DW-1:0]     digit;
    logic [2:0]        opcode;
    logic              is_op;
    logic              is_result;
    logic              is_enter;
    logic [4*RW-1:0]   result_flat;
    logic              result_valid;
    logic              busy;
    logic              err;
    logic              cur_mat;
    logic [1:0]        cur_idx;

    modport master (
        output digit_valid, digit, opcode, is_op, is_result, is_enter,
        input  result_flat, result_valid, busy, err, cur_mat, cur_idx
    );

    modport slave (
        input  digit_valid, digit, opcode, is_op, is_result, is_enter,
        output result_flat, result_valid, busy, err, cur_mat, cur_idx
    );
endinterface

// File: rtl/matrix_op_controller.sv
// Collects two 2x2 operand matrices from key events, then adds or subtracts them
// element-serially and holds the 2x2 result for the display stage.
module matrix_op_controller #(
    parameter int DW = 4,
    parameter int RW = DW + 1
) (
    input  logic        clk,
    input  logic        nrst,
    matrix_op_if.slave  bus
);
    typedef enum logic [2:0] {
        ST_ENTER_A = 3'd0,
        ST_WAIT_OP = 3'd1,
        ST_ENTER_B = 3'd2,
        ST_WAIT_EQ = 3'd3,
        ST_COMPUTE = 3'd4,
        ST_DONE    = 3'd5
    } state_t;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;

    state_t            state_r, state_n;
    logic [1:0]        idx_r, idx_n;
    logic              cur_mat_r, cur_mat_n;
    logic [DW-1:0]     mat_a_r [4];
    logic [DW-1:0]     mat_b_r [4];
    logic [DW-1:0]     pending_r;
    logic              pending_v_r;
    logic [2:0]        op_r;
    logic [4*RW-1:0]   result_r;
    logic              result_valid_r;
    logic              busy_r;
    logic              err_r;

    logic              res_ev_s;
    logic              have_data_s;
    logic [DW-1:0]     commit_data_s;
    logic              commit_s;
    logic              err_s;
    logic              op_load_s;
    logic              calc_s;
    logic [RW-1:0]     elem_s;

    // An operator key wins over a simultaneous result key.
    assign res_ev_s      = bus.is_result & ~bus.is_op;
    assign have_data_s   = pending_v_r | bus.digit_valid;
    assign commit_data_s = bus.digit_valid ? bus.digit : pending_r;

    // Next-state, commit and error decode.
    always_comb begin
        state_n   = state_r;
        idx_n     = idx_r;
        cur_mat_n = cur_mat_r;
        commit_s  = 1'b0;
        err_s     = 1'b0;
        op_load_s = 1'b0;
        calc_s    = 1'b0;
        case (state_r)
            ST_ENTER_A, ST_ENTER_B: begin
                if (bus.is_op || res_ev_s) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
                if (bus.is_enter && have_data_s) begin
                    commit_s = 1'b1;
                    idx_n    = idx_r + 2'd1;
                    if (idx_r == 2'd3) begin
                        state_n = (state_r == ST_ENTER_A) ? ST_WAIT_OP : ST_WAIT_EQ;
                    end else begin
                        state_n = state_r;
                    end
                end else if (bus.is_enter) begin
                    err_s = 1'b1;
                end else begin
                    commit_s = 1'b0;
                end
            end
            ST_WAIT_OP: begin
                if (bus.is_op && (bus.opcode == OP_ADD || bus.opcode == OP_SUB)) begin
                    op_load_s = 1'b1;
                    cur_mat_n = 1'b1;
                    state_n   = ST_ENTER_B;
                    err_s     = bus.is_enter;
                end else if (bus.is_op || res_ev_s || bus.is_enter) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
            end
            ST_WAIT_EQ: begin
                if (bus.is_op || bus.is_enter) begin
                    err_s = 1'b1;
                end else begin
                    err_s = 1'b0;
                end
                if (res_ev_s) begin
                    state_n = ST_COMPUTE;
                end else begin
                    state_n = ST_WAIT_EQ;
                end
            end
            ST_COMPUTE: begin
                calc_s = 1'b1;
                idx_n  = idx_r + 2'd1;
                if (idx_r == 2'd3) begin
                    state_n = ST_DONE;
                end else begin
                    state_n = ST_COMPUTE;
                end
            end
            ST_DONE: begin
                err_s = res_ev_s;
                if (bus.is_enter) begin
                    state_n   = ST_ENTER_A;
                    cur_mat_n = 1'b0;
                    idx_n     = 2'd0;
                end else begin
                    state_n = ST_DONE;
                end
            end
            default: begin
                state_n   = ST_ENTER_A;
                idx_n     = 2'd0;
                cur_mat_n = 1'b0;
            end
        endcase
    end

    // Element-wise arithmetic on zero-extended operands; RW bits cannot overflow.
    always_comb begin
        elem_s = {1'b0, mat_a_r[idx_r]} + {1'b0, mat_b_r[idx_r]};
        if (op_r == OP_SUB) begin
            elem_s = {1'b0, mat_a_r[idx_r]} - {1'b0, mat_b_r[idx_r]};
        end else begin
            elem_s = {1'b0, mat_a_r[idx_r]} + {1'b0, mat_b_r[idx_r]};
        end
    end

    // State, operand storage, pending digit and registered outputs.
    always_ff @(posedge clk) begin
        if (!nrst) begin
            state_r        <= ST_ENTER_A;
            idx_r          <= 2'd0;
            cur_mat_r      <= 1'b0;
            pending_r      <= '0;
            pending_v_r    <= 1'b0;
            op_r           <= 3'd0;
            result_r       <= '0;
            result_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            err_r          <= 1'b0;
            for (int k = 0; k < 4; k++) begin
                mat_a_r[k] <= '0;
                mat_b_r[k] <= '0;
            end
        end else begin
            state_r        <= state_n;
            idx_r          <= idx_n;
            cur_mat_r      <= cur_mat_n;
            err_r          <= err_s;
            busy_r         <= (state_n == ST_COMPUTE);
            result_valid_r <= (state_r == ST_DONE) && (state_n == ST_DONE);
            if (commit_s && cur_mat_r) begin
                mat_b_r[idx_r] <= commit_data_s;
            end else if (commit_s) begin
                mat_a_r[idx_r] <= commit_data_s;
            end else begin
                mat_a_r[idx_r] <= mat_a_r[idx_r];
            end
            // A forwarded digit is consumed by the commit, so it never lingers as pending.
            if (commit_s) begin
                pending_v_r <= 1'b0;
            end else if (bus.digit_valid && state_r != ST_COMPUTE) begin
                pending_r   <= bus.digit;
                pending_v_r <= 1'b1;
            end else begin
                pending_v_r <= pending_v_r;
            end
            if (op_load_s) begin
                op_r <= bus.opcode;
            end else begin
                op_r <= op_r;
            end
            if (calc_s) begin
                result_r[int'(idx_r)*RW +: RW] <= elem_s;
            end else begin
                result_r <= result_r;
            end
        end
    end

    assign bus.result_flat  = result_r;
    assign bus.result_valid = result_valid_r;
    assign bus.busy         = busy_r;
    assign bus.err          = err_r;
    assign bus.cur_mat      = cur_mat_r;
    assign bus.cur_idx      = idx_r;
endmodule

// File: tb/tb_matrix_op_controller.sv
// Directed bench for matrix_op_controller: expected results go to a scoreboard that a
// separate monitor drains on each rising result_valid.
module tb_matrix_op_controller;
    logic clk  = 1'b0;
    logic nrst = 1'b0;
    int   cyc  = 0;

    matrix_op_if #(.DW(4)) bus ();

    matrix_op_controller #(.DW(4)) dut (
        .clk  (clk),
        .nrst (nrst),
        .bus  (bus)
    );

    typedef struct {
        logic [19:0] flat;
        int          t_ev;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   err_cnt  = 0;
    int   exp_err  = 0;
    logic rv_prev  = 1'b0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] pack(input logic [4:0] r0, input logic [4:0] r1,
                                         input logic [4:0] r2, input logic [4:0] r3);
        return {r3, r2, r1, r0};
    endfunction

    // Monitor: scoreboard pop on each new result, plus err pulse counting.
    always @(negedge clk) begin
        if (bus.result_valid && !rv_prev) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_result: got %0h expected none", bus.result_flat);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("result_flat", bus.result_flat, e.flat);
                check("result_latency", cyc - e.t_ev, 5);
            end
        end
        if (bus.err) err_cnt++;
        rv_prev = bus.result_valid;
    end

    task automatic key(input logic dv, input logic [3:0] d, input logic op,
                       input logic [2:0] opc, input logic res, input logic ent);
        bus.digit_valid = dv;
        bus.digit       = d;
        bus.is_op       = op;
        bus.opcode      = opc;
        bus.is_result   = res;
        bus.is_enter    = ent;
        @(posedge clk);
        #1;
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.is_op       = 1'b0;
        bus.opcode      = 3'd0;
        bus.is_result   = 1'b0;
        bus.is_enter    = 1'b0;
    endtask

    task automatic chk_err(input string name);
        @(negedge clk);
        #1;
        check(name, err_cnt, exp_err);
    endtask

    task automatic enter_elem(input logic [3:0] d);
        key(1'b1, d, 1'b0, 3'd0, 1'b0, 1'b0);
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
    endtask

    task automatic enter4(input logic [15:0] v);
        for (int k = 0; k < 4; k++) enter_elem(v[k*4 +: 4]);
    endtask

    task automatic finish_run(input logic [19:0] expflat);
        exp_t e;
        bit   seen;
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        e.flat = expflat;
        e.t_ev = cyc;
        sb_q.push_back(e);
        for (int k = 0; k < 4; k++) begin
            check("busy_during_compute", bus.busy, 1'b1);
            @(posedge clk);
            #1;
        end
        check("busy_after_compute", bus.busy, 1'b0);
        seen = 1'b0;
        for (int k = 0; k < 10 && !seen; k++) begin
            if (bus.result_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        check("result_valid_timeout", seen, 1'b1);
        @(posedge clk);
        #1;
        check("result_valid_held", bus.result_valid, 1'b1);
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        check("rv_cleared", bus.result_valid, 1'b0);
        check("cur_mat_cleared", bus.cur_mat, 1'b0);
        check("cur_idx_cleared", bus.cur_idx, 2'd0);
    endtask

    task automatic run_calc(input logic [15:0] a, input logic [2:0] opc,
                            input logic [15:0] b, input logic [19:0] expflat);
        enter4(a);
        check("wait_op_mat", bus.cur_mat, 1'b0);
        key(1'b0, 4'd0, 1'b1, opc, 1'b0, 1'b0);
        check("op_select_mat", bus.cur_mat, 1'b1);
        enter4(b);
        finish_run(expflat);
    endtask

    initial begin
        bus.digit_valid = 1'b0;
        bus.digit       = 4'd0;
        bus.is_op       = 1'b0;
        bus.opcode      = 3'd0;
        bus.is_result   = 1'b0;
        bus.is_enter    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_result_valid", bus.result_valid, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        check("rst_err", bus.err, 1'b0);
        check("rst_cur_mat", bus.cur_mat, 1'b0);
        check("rst_cur_idx", bus.cur_idx, 2'd0);
        check("rst_result_flat", bus.result_flat, 20'd0);
        nrst = 1'b1;
        @(posedge clk);
        #1;

        // Add: {1,2,3,4} + {5,6,7,8}
        run_calc(16'h4321, 3'b001, 16'h8765, pack(5'd6, 5'd8, 5'd10, 5'd12));
        chk_err("add_no_err");

        // Sub with a negative element: {3,0,15,7} - {5,0,1,7}
        run_calc(16'h7F03, 3'b010, 16'h7105, pack(5'h1E, 5'd0, 5'd14, 5'd0));
        chk_err("sub_no_err");

        // Illegal events, forwarding and combined operator/result key
        enter_elem(4'd2);
        enter_elem(4'd4);
        check("idx_after_two", bus.cur_idx, 2'd2);
        key(1'b0, 4'd0, 1'b1, 3'b001, 1'b0, 1'b0);
        exp_err++;
        chk_err("op_in_enter_a_err");
        check("op_in_enter_a_idx", bus.cur_idx, 2'd2);
        check("op_in_enter_a_mat", bus.cur_mat, 1'b0);
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        exp_err++;
        chk_err("empty_enter_err");
        check("empty_enter_idx", bus.cur_idx, 2'd2);
        key(1'b1, 4'd9, 1'b0, 3'd0, 1'b0, 1'b1);
        check("forward_idx", bus.cur_idx, 2'd3);
        chk_err("forward_no_err");
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b0, 1'b1);
        exp_err++;
        chk_err("enter_after_forward_err");
        check("enter_after_forward_idx", bus.cur_idx, 2'd3);
        enter_elem(4'd1);
        check("wait_op_idx", bus.cur_idx, 2'd0);
        key(1'b0, 4'd0, 1'b1, 3'b011, 1'b0, 1'b0);
        exp_err++;
        chk_err("bad_opcode_err");
        check("bad_opcode_mat", bus.cur_mat, 1'b0);
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        exp_err++;
        chk_err("result_in_wait_op_err");
        key(1'b0, 4'd0, 1'b1, 3'b001, 1'b1, 1'b0);
        check("combined_key_mat", bus.cur_mat, 1'b1);
        chk_err("combined_key_no_err");
        enter4(16'h1111);
        finish_run(pack(5'd3, 5'd5, 5'd10, 5'd2));
        chk_err("illegal_run_err_total");

        // Reset during the second compute cycle aborts the result
        enter4(16'h1111);
        key(1'b0, 4'd0, 1'b1, 3'b001, 1'b0, 1'b0);
        enter4(16'h1111);
        key(1'b0, 4'd0, 1'b0, 3'd0, 1'b1, 1'b0);
        @(posedge clk);
        #1;
        nrst = 1'b0;
        @(posedge clk);
        #1;
        check("midrst_result_valid", bus.result_valid, 1'b0);
        check("midrst_busy", bus.busy, 1'b0);
        check("midrst_err", bus.err, 1'b0);
        check("midrst_cur_mat", bus.cur_mat, 1'b0);
        check("midrst_cur_idx", bus.cur_idx, 2'd0);
        check("midrst_result_flat", bus.result_flat, 20'd0);
        nrst = 1'b1;
        repeat (8) @(posedge clk);
        #1;
        check("midrst_no_result", bus.result_valid, 1'b0);
        run_calc(16'h4321, 3'b001, 16'h8765, pack(5'd6, 5'd8, 5'd10, 5'd12));
        chk_err("final_err_total");

        repeat (2) @(posedge clk);
        #1;
        check("scoreboard_drained", sb_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule

// File: doc/matrix_op_controller.md
Name: matrix_op_controller

Overview:
- Sits directly downstream of the opcode encoder and a digit-entry encoder.
- Consumes single-cycle key events and stores two 2x2 operand matrices (A, B) of unsigned DW-bit elements.
- Latches the selected operation (add/sub) and runs a 4-cycle element-serial compute.
- Presents the 2x2 result to the display stage with a held valid flag.

Parameters:
- DW, 4, operand element width (unsigned).
- RW, DW+1, result element width (two's complement); must equal DW+1.

Ports:
- clk  input  1  system clock, all state updates on rising edge
- nrst  input  1  reset, synchronous, active-low
- digit_valid  input  1  one-cycle pulse, new digit available
- digit  input  DW  digit value, qualified by digit_valid
- opcode  input  3  3'b001 = add, 3'b010 = sub; qualified by is_op
- is_op  input  1  one-cycle operator-key event
- is_result  input  1  one-cycle result-key event
- is_enter  input  1  one-cycle commit-element event
- result_flat  output  4*RW  element k at bits [k*RW +: RW], k = row*2 + col
- result_valid  output  1  high while result_flat holds a completed result
- busy  output  1  high during COMPUTE
- err  output  1  one-cycle pulse on an illegal event
- cur_mat  output  1  0 = entering A, 1 = entering B
- cur_idx  output  2  element slot the next commit writes

Behaviour:
- Reset (nrst = 0 at clk edge)
  - Highest priority over every other input.
  - State goes to ENTER_A; A, B, result_flat, pending, op and idx clear to 0.
  - result_valid, busy, err, cur_mat are 0 out of reset.
  - Reset mid-COMPUTE aborts the compute, and no result_valid is produced.
- Pending digit register
  - digit_valid loads pending <= digit and sets pending_v = 1; a later digit overwrites it.
  - If is_enter and digit_valid occur in the same cycle, the incoming digit is committed directly (forwarded).
  - In that case pending_v ends at 0.
- Commit
  - is_enter with (pending_v or digit_valid) in an ENTER state writes cur_mat[idx].
  - It then increments idx and clears pending_v.
  - is_enter with neither pending_v nor digit_valid: no write, err pulse.
- ENTER_A: after the commit to idx 3, idx wraps to 0 and the state goes to WAIT_OP.
- WAIT_OP
  - is_op with opcode 001 or 010 latches op, sets cur_mat = 1, and goes to ENTER_B.
  - is_op with any other opcode: err pulse, stay.
- ENTER_B: after the commit to idx 3, idx wraps to 0 and the state goes to WAIT_EQ.
- WAIT_EQ: result event is is_result = 1 && is_op = 0; it goes to COMPUTE.
  - is_result together with is_op (an operator key) is an operator event, not a result event.
- Out-of-order events (err pulse, event ignored, state unchanged)
  - is_op in ENTER_A, ENTER_B or WAIT_EQ.
  - A result event in any state other than WAIT_EQ.
  - is_enter in WAIT_OP or WAIT_EQ.
- COMPUTE
  - busy = 1.
  - One element per cycle, idx 0..3: R[k] = zext(A[k]) + zext(B[k]) for add, or zext(A[k]) - zext(B[k]) for sub.
  - R[k] is RW-bit two's complement, with no overflow possible.
  - All key events in COMPUTE are ignored without err.
  - After the idx 3 write, go to DONE.
- DONE
  - result_valid = 1, held.
  - is_enter clears result_valid, clears cur_mat and idx, and goes to ENTER_A.
  - A and B are retained until overwritten.
- Latency: if a result event is sampled at edge t, result_valid is first high after edge t+5.
- Other outputs
  - err is registered and is high exactly one cycle per illegal event.
  - cur_mat and cur_idx reflect the registered state.

Test Plan:
- Add: enter A = {1,2,3,4} (digit then enter, each), op 001, B = {5,6,7,8}, result event -> busy high 4 cycles, then result_valid = 1 with R = {6,8,10,12}, err never pulsed.
- Sub, negative: A = {3,0,15,7}, op 010, B = {5,0,1,7} -> R = {5'h1E, 0, 14, 0} (-2, 0, 14, 0), result_valid 5 edges after the result event.
- Illegal events: is_op (001) after only 2 A elements -> err pulses once, cur_idx stays 2; is_enter with no digit -> err, no write; is_op opcode 011 in WAIT_OP -> err, state stays WAIT_OP.
- Forwarding: digit_valid = 1, digit = 9, is_enter = 1 in the same cycle -> A[idx] = 9, pending_v = 0, idx += 1; next is_enter alone -> err.
- Combined key: is_op = 1 and is_result = 1 with opcode 001 in WAIT_OP -> treated as add select (ENTER_B), not as a result event.
- Reset mid-compute: drive nrst = 0 at the second COMPUTE cycle -> next edge all outputs 0, state ENTER_A, no result_valid; then a full add run completes normally.
